// File: rtl/jbi_sc_req_tx_pkg.sv
// jbi_sc_pkg: shared types and constants for the JBI->SCTAG request transmitter.
//   - FSM state enum
//   - header beat count, default credit / beat counts
//   - beat, ECC and buffer entry widths
//   - helper to pack a data word with its check bits into a buffer entry
package jbi_sc_pkg;

    localparam int unsigned JBI_SC_HDR_BEATS   = 2;
    localparam int unsigned JBI_SC_IQ_CREDITS  = 16;
    localparam int unsigned JBI_SC_WIB_CREDITS = 4;
    localparam int unsigned JBI_SC_WR_BEATS    = 16;

    localparam int unsigned JBI_SC_BEAT_W  = 32;
    localparam int unsigned JBI_SC_ECC_W   = 7;
    localparam int unsigned JBI_SC_HDR_W   = JBI_SC_HDR_BEATS * JBI_SC_BEAT_W;
    localparam int unsigned JBI_SC_ENTRY_W = JBI_SC_ECC_W + JBI_SC_BEAT_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR0 = 2'd1,
        ST_HDR1 = 2'd2,
        ST_DATA = 2'd3
    } jbi_sc_state_e;

    function automatic logic [JBI_SC_ENTRY_W-1:0] jbi_sc_pack(
        input logic [JBI_SC_BEAT_W-1:0] word,
        input logic [JBI_SC_ECC_W-1:0]  ecc
    );
        return {ecc, word};
    endfunction

endpackage

// File: rtl/jbi_sc_req_tx_if.sv
// jbi_sc_req_tx_if: request descriptor and write-data handshake between the
// JBI core (master) and the request transmitter (slave).
//   up_vld/up_rdy/up_hdr/up_is_wr : request descriptor handshake
//   dat_vld/dat_rdy/dat_word/dat_ecc : write data word handshake
interface jbi_sc_req_tx_if;
    import jbi_sc_pkg::*;

    logic                     up_vld;
    logic                     up_rdy;
    logic [JBI_SC_HDR_W-1:0]  up_hdr;
    logic                     up_is_wr;
    logic                     dat_vld;
    logic                     dat_rdy;
    logic [JBI_SC_BEAT_W-1:0] dat_word;
    logic [JBI_SC_ECC_W-1:0]  dat_ecc;

    modport master (
        output up_vld, up_hdr, up_is_wr, dat_vld, dat_word, dat_ecc,
        input  up_rdy, dat_rdy
    );

    modport slave (
        input  up_vld, up_hdr, up_is_wr, dat_vld, dat_word, dat_ecc,
        output up_rdy, dat_rdy
    );

endinterface

// File: rtl/jbi_sc_req_tx_credit_cnt.sv
// jbi_sc_credit_cnt: saturating credit counter, resets to MAX.
//   clk, rst_l : clock, async active-low reset
//   inc        : credit returned
//   dec        : credit consumed (caller guarantees avail)
//   avail      : at least one credit held
//   ovf        : return arrived while already full (single-cycle pulse)
module jbi_sc_credit_cnt #(
    parameter int unsigned MAX = 16,
    localparam int unsigned CW = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst_l,
    input  logic inc,
    input  logic dec,
    output logic avail,
    output logic ovf
);
    localparam logic [CW-1:0] FULL = CW'(MAX);

    logic [CW-1:0] cnt;

    assign avail = (cnt != '0);
    // A simultaneous return and consume cancel, so they never overflow.
    assign ovf   = inc & ~dec & (cnt == FULL);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt <= FULL;
        end else if (inc & ~dec) begin
            if (cnt != FULL) cnt <= cnt + 1'b1;
        end else if (dec & ~inc) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/jbi_sc_req_tx.sv
// jbi_sc_req_tx: serializes JBI request descriptors and write data into
// 32-bit beats for the SCTAG and tracks IQ/WIB credits.
//   rclk, rst_l            : clock, async active-low reset
//   up                     : descriptor + write data handshake (slave side)
//   sctag_jbi_iq_dequeue   : IQ credit return
//   sctag_jbi_wib_dequeue  : WIB credit return
//   sctag_jbi_por_req      : blocks acceptance of new packets while high
//   jbi_sctag_req/_vld     : registered request/data beat
//   jbi_scbuf_ecc          : registered ECC of the data beat, 0 on headers
//   idle                   : FSM idle and data buffer empty
//   credit_err             : sticky credit overflow flag
module jbi_sc_req_tx
    import jbi_sc_pkg::*;
#(
    parameter int unsigned IQ_CREDITS  = JBI_SC_IQ_CREDITS,
    parameter int unsigned WIB_CREDITS = JBI_SC_WIB_CREDITS,
    parameter int unsigned WR_BEATS    = JBI_SC_WR_BEATS
) (
    input  logic                     rclk,
    input  logic                     rst_l,
    jbi_sc_req_tx_if.slave           up,
    input  logic                     sctag_jbi_iq_dequeue,
    input  logic                     sctag_jbi_wib_dequeue,
    input  logic                     sctag_jbi_por_req,
    output logic [JBI_SC_BEAT_W-1:0] jbi_sctag_req,
    output logic [JBI_SC_ECC_W-1:0]  jbi_scbuf_ecc,
    output logic                     jbi_sctag_req_vld,
    output logic                     idle,
    output logic                     credit_err
);
    localparam int unsigned PW  = (WR_BEATS > 1) ? $clog2(WR_BEATS) : 1;
    localparam int unsigned BCW = $clog2(WR_BEATS + 1);
    localparam logic [PW-1:0]  LAST_IDX = PW'(WR_BEATS - 1);
    localparam logic [BCW-1:0] BUF_FULL = BCW'(WR_BEATS);

    jbi_sc_state_e state;
    logic [JBI_SC_BEAT_W-1:0]  hdr_lo;
    logic                      is_wr_q;
    logic [PW-1:0]             beat_cnt;

    logic [JBI_SC_ENTRY_W-1:0] buf_mem [WR_BEATS];
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic [BCW-1:0]            buf_cnt;
    logic                      buf_full;
    logic                      push;
    logic                      pop;

    logic iq_avail, iq_ovf, wib_avail, wib_ovf;
    logic accept;

    assign buf_full   = (buf_cnt == BUF_FULL);
    assign push       = up.dat_vld & ~buf_full;
    assign up.dat_rdy = rst_l & ~buf_full;

    // Writes wait for a full buffer so the data beats never stall.
    assign accept = rst_l & (state == ST_IDLE) & up.up_vld & iq_avail & ~sctag_jbi_por_req &
                    (~up.up_is_wr | (wib_avail & buf_full));
    assign up.up_rdy = accept;

    assign idle = rst_l & (state == ST_IDLE) & (buf_cnt == '0);

    always_comb begin
        pop = 1'b0;
        if (state == ST_HDR1)      pop = is_wr_q;
        else if (state == ST_DATA) pop = (beat_cnt != LAST_IDX);
    end

    jbi_sc_credit_cnt #(.MAX(IQ_CREDITS)) u_iq (
        .clk   (rclk),
        .rst_l (rst_l),
        .inc   (sctag_jbi_iq_dequeue),
        .dec   (accept),
        .avail (iq_avail),
        .ovf   (iq_ovf)
    );

    jbi_sc_credit_cnt #(.MAX(WIB_CREDITS)) u_wib (
        .clk   (rclk),
        .rst_l (rst_l),
        .inc   (sctag_jbi_wib_dequeue),
        .dec   (accept & up.up_is_wr),
        .avail (wib_avail),
        .ovf   (wib_ovf)
    );

    always_ff @(posedge rclk) begin
        if (push) buf_mem[wr_ptr] <= jbi_sc_pack(up.dat_word, up.dat_ecc);
    end

    always_ff @(posedge rclk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            buf_cnt <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
            if (push & ~pop)      buf_cnt <= buf_cnt + 1'b1;
            else if (pop & ~push) buf_cnt <= buf_cnt - 1'b1;
        end
    end

    // Output registers load the beat belonging to the state being entered,
    // so each state's beat is on the bus during that state's own cycle.
    always_ff @(posedge rclk or negedge rst_l) begin
        if (!rst_l) begin
            state             <= ST_IDLE;
            hdr_lo            <= '0;
            is_wr_q           <= 1'b0;
            beat_cnt          <= '0;
            jbi_sctag_req     <= '0;
            jbi_scbuf_ecc     <= '0;
            jbi_sctag_req_vld <= 1'b0;
            credit_err        <= 1'b0;
        end else begin
            credit_err        <= credit_err | iq_ovf | wib_ovf;
            jbi_sctag_req     <= '0;
            jbi_scbuf_ecc     <= '0;
            jbi_sctag_req_vld <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state             <= ST_HDR0;
                        hdr_lo            <= up.up_hdr[JBI_SC_BEAT_W-1:0];
                        is_wr_q           <= up.up_is_wr;
                        jbi_sctag_req     <= up.up_hdr[JBI_SC_HDR_W-1:JBI_SC_BEAT_W];
                        jbi_sctag_req_vld <= 1'b1;
                    end
                end
                ST_HDR0: begin
                    state             <= ST_HDR1;
                    jbi_sctag_req     <= hdr_lo;
                    jbi_sctag_req_vld <= 1'b1;
                end
                ST_HDR1: begin
                    if (is_wr_q) begin
                        state                           <= ST_DATA;
                        beat_cnt                        <= '0;
                        {jbi_scbuf_ecc, jbi_sctag_req}  <= buf_mem[rd_ptr];
                        jbi_sctag_req_vld               <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (beat_cnt == LAST_IDX) begin
                        state <= ST_IDLE;
                    end else begin
                        beat_cnt                        <= beat_cnt + 1'b1;
                        {jbi_scbuf_ecc, jbi_sctag_req}  <= buf_mem[rd_ptr];
                        jbi_sctag_req_vld               <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jbi_sc_req_tx.sv
// Testbench for jbi_sc_req_tx: directed vectors, hand-written corner cases and
// randomized traffic checked against a beat-schedule reference model.
module tb_jbi_sc_req_tx;
    import jbi_sc_pkg::*;

    localparam int IQ  = 16;
    localparam int WIB = 4;
    localparam int WR  = 16;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        iq_deq = 1'b0;
    logic        wib_deq = 1'b0;
    logic        por = 1'b0;
    logic [31:0] req;
    logic [6:0]  ecc;
    logic        vld;
    logic        idle;
    logic        credit_err;

    jbi_sc_req_tx_if bus();

    jbi_sc_req_tx #(.IQ_CREDITS(IQ), .WIB_CREDITS(WIB), .WR_BEATS(WR)) dut (
        .rclk                  (clk),
        .rst_l                 (rst_l),
        .up                    (bus.slave),
        .sctag_jbi_iq_dequeue  (iq_deq),
        .sctag_jbi_wib_dequeue (wib_deq),
        .sctag_jbi_por_req     (por),
        .jbi_sctag_req         (req),
        .jbi_scbuf_ecc         (ecc),
        .jbi_sctag_req_vld     (vld),
        .idle                  (idle),
        .credit_err            (credit_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [6:0] ecc_of(input logic [31:0] w);
        return w[6:0] ^ w[13:7] ^ 7'h55;
    endfunction

    // ---------------- reference model ----------------
    // exp_q holds the beats still to appear on the bus, one per cycle; the FSM
    // is idle whenever nothing is scheduled. Data beats leave the buffer one
    // cycle before they appear on the bus.
    typedef struct {
        logic [38:0] val;
        bit          is_data;
    } beat_t;

    beat_t       exp_q[$];
    logic [38:0] mbuf[$];
    int          m_iq  = IQ;
    int          m_wib = WIB;
    bit          m_err = 1'b0;

    always @(negedge clk) begin : model
        beat_t cur;
        beat_t b;
        bit    have;
        bit    e_rdy;
        bit    pop;
        bit    push;
        if (!rst_l) begin
            chk("rst_vld", vld, 0);
            chk("rst_req", req, 0);
            chk("rst_ecc", ecc, 0);
            chk("rst_up_rdy", bus.up_rdy, 0);
            chk("rst_dat_rdy", bus.dat_rdy, 0);
            chk("rst_idle", idle, 0);
            chk("rst_credit_err", credit_err, 0);
            exp_q.delete();
            mbuf.delete();
            m_iq  = IQ;
            m_wib = WIB;
            m_err = 1'b0;
        end else begin
            have = (exp_q.size() > 0);
            cur.val = '0;
            cur.is_data = 1'b0;
            if (have) cur = exp_q.pop_front();
            chk("m_vld", vld, have);
            chk("m_req", req, cur.val[31:0]);
            chk("m_ecc", ecc, cur.val[38:32]);
            e_rdy = !have && bus.up_vld && m_iq > 0 && !por &&
                    (!bus.up_is_wr || (m_wib > 0 && mbuf.size() == WR));
            chk("m_up_rdy", bus.up_rdy, e_rdy);
            chk("m_dat_rdy", bus.dat_rdy, mbuf.size() != WR);
            chk("m_idle", idle, !have && mbuf.size() == 0);
            chk("m_credit_err", credit_err, m_err);
            chk("m_iq_cnt", dut.u_iq.cnt, m_iq);
            chk("m_wib_cnt", dut.u_wib.cnt, m_wib);

            pop  = (exp_q.size() > 0) && exp_q[0].is_data;
            push = bus.dat_vld && mbuf.size() < WR;
            if (e_rdy) begin
                b.is_data = 1'b0;
                b.val = {7'b0, bus.up_hdr[63:32]};
                exp_q.push_back(b);
                b.val = {7'b0, bus.up_hdr[31:0]};
                exp_q.push_back(b);
                if (bus.up_is_wr) begin
                    for (int i = 0; i < WR; i++) begin
                        b.is_data = 1'b1;
                        b.val = mbuf[i];
                        exp_q.push_back(b);
                    end
                end
            end
            if (pop)  mbuf.delete(0);
            if (push) mbuf.push_back({bus.dat_ecc, bus.dat_word});

            if (iq_deq && !e_rdy) begin
                if (m_iq == IQ) m_err = 1'b1; else m_iq++;
            end else if (e_rdy && !iq_deq) begin
                m_iq--;
            end
            if (wib_deq && !(e_rdy && bus.up_is_wr)) begin
                if (m_wib == WIB) m_err = 1'b1; else m_wib++;
            end else if (e_rdy && bus.up_is_wr && !wib_deq) begin
                m_wib--;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.up_vld   = 1'b0;
        bus.up_hdr   = '0;
        bus.up_is_wr = 1'b0;
        bus.dat_vld  = 1'b0;
        bus.dat_word = '0;
        bus.dat_ecc  = '0;
        iq_deq       = 1'b0;
        wib_deq      = 1'b0;
        por          = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_l = 1'b0;
        step();
        step();
        rst_l = 1'b1;
    endtask

    task automatic fill_buf(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            bus.dat_vld  = 1'b1;
            bus.dat_word = base + 32'(i);
            bus.dat_ecc  = ecc_of(base + 32'(i));
            step();
        end
        bus.dat_vld = 1'b0;
    endtask

    // Returns in the cycle after acceptance (T+1).
    task automatic send(input logic [63:0] hdr, input bit wr, input int budget);
        bit done;
        done = 1'b0;
        bus.up_vld   = 1'b1;
        bus.up_hdr   = hdr;
        bus.up_is_wr = wr;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (bus.up_rdy === 1'b1) done = 1'b1;
            step();
        end
        bus.up_vld   = 1'b0;
        bus.up_is_wr = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    typedef struct {
        bit vld;
        bit wr;
        bit por;
        bit rdy;
    } vec_t;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        vec_t tbl[8];
        int   nv;
        bit   blocked;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1};

        clear_inputs();
        step();
        do_reset();
        @(negedge clk);
        chk("post_rst_idle", idle, 1);
        chk("post_rst_dat_rdy", bus.dat_rdy, 1);
        step();

        // Read request
        send(64'hA5A5_0000_1234_5678, 1'b0, 10);
        @(negedge clk);
        chk("rd_hi", req, 32'hA5A5_0000);
        chk("rd_hi_vld", vld, 1);
        chk("rd_hi_ecc", ecc, 0);
        chk("rd_iq", dut.u_iq.cnt, 15);
        @(negedge clk);
        chk("rd_lo", req, 32'h1234_5678);
        @(negedge clk);
        chk("rd_end_vld", vld, 0);
        chk("rd_end_idle", idle, 1);
        step();

        // Write request with words 0..15
        do_reset();
        fill_buf(16, 32'h0);
        @(negedge clk);
        chk("wr_buf_full", bus.dat_rdy, 0);
        step();
        send(64'hDEAD_BEEF_0BAD_F00D, 1'b1, 10);
        @(negedge clk);
        chk("wr_hi", req, 32'hDEAD_BEEF);
        chk("wr_iq", dut.u_iq.cnt, 15);
        chk("wr_wib", dut.u_wib.cnt, 3);
        @(negedge clk);
        chk("wr_lo", req, 32'h0BAD_F00D);
        for (int i = 0; i < WR; i++) begin
            @(negedge clk);
            chk("wr_data_vld", vld, 1);
            chk("wr_data", req, i);
            chk("wr_ecc", ecc, ecc_of(32'(i)));
        end
        @(negedge clk);
        chk("wr_end_vld", vld, 0);
        step();

        // IQ credit exhaustion
        do_reset();
        for (int i = 0; i < IQ; i++) send({32'h1000_0000 + 32'(i), 32'(i)}, 1'b0, 10);
        bus.up_vld = 1'b1;
        bus.up_hdr = 64'h1111_2222_3333_4444;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("exh_blocked", bus.up_rdy, 0);
            step();
        end
        iq_deq = 1'b1;
        @(negedge clk);
        chk("exh_deq_cycle", bus.up_rdy, 0);
        step();
        iq_deq = 1'b0;
        @(negedge clk);
        chk("exh_after_deq", bus.up_rdy, 1);
        step();
        bus.up_vld = 1'b0;
        @(negedge clk);
        chk("exh_hi", req, 32'h1111_2222);
        chk("exh_iq_zero", dut.u_iq.cnt, 0);
        step();
        repeat (3) step();

        // Simultaneous consume/return, then return at max
        do_reset();
        bus.up_vld = 1'b1;
        bus.up_hdr = 64'h5555_6666_7777_8888;
        iq_deq = 1'b1;
        @(negedge clk);
        chk("sim_rdy", bus.up_rdy, 1);
        step();
        bus.up_vld = 1'b0;
        iq_deq = 1'b0;
        @(negedge clk);
        chk("sim_iq", dut.u_iq.cnt, 16);
        chk("sim_err", credit_err, 0);
        step();
        repeat (3) step();
        iq_deq = 1'b1;
        step();
        iq_deq = 1'b0;
        @(negedge clk);
        chk("max_err", credit_err, 1);
        chk("max_iq", dut.u_iq.cnt, 16);
        step();
        repeat (5) step();
        @(negedge clk);
        chk("max_err_sticky", credit_err, 1);
        step();

        // POR asserted mid-write
        do_reset();
        fill_buf(16, 32'h200);
        send(64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 10);
        step();
        step();
        por = 1'b1;
        bus.up_vld = 1'b1;
        bus.up_is_wr = 1'b0;
        bus.up_hdr = 64'h0123_4567_89AB_CDEF;
        nv = 0;
        blocked = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (vld) nv++;
            if (bus.up_rdy) blocked = 1'b0;
            step();
        end
        chk("por_data_beats", 64'(nv), 16);
        chk("por_blocked", blocked, 1);
        por = 1'b0;
        @(negedge clk);
        chk("por_release", bus.up_rdy, 1);
        step();
        bus.up_vld = 1'b0;
        repeat (4) step();

        // Write gated until the 16th word arrives
        do_reset();
        fill_buf(15, 32'h300);
        bus.up_vld = 1'b1;
        bus.up_is_wr = 1'b1;
        bus.up_hdr = 64'hFEED_0000_FACE_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b15_block", bus.up_rdy, 0);
            step();
        end
        bus.dat_vld = 1'b1;
        bus.dat_word = 32'h30F;
        bus.dat_ecc = ecc_of(32'h30F);
        @(negedge clk);
        chk("b15_push_cycle", bus.up_rdy, 0);
        step();
        bus.dat_vld = 1'b0;
        @(negedge clk);
        chk("b16_rdy", bus.up_rdy, 1);
        step();
        bus.up_vld = 1'b0;
        bus.up_is_wr = 1'b0;
        repeat (20) step();

        // Reset during data beat 5
        do_reset();
        fill_buf(16, 32'h400);
        send(64'h9999_8888_7777_6666, 1'b1, 10);
        repeat (7) step();
        @(negedge clk);
        chk("mid_beat5", req, 32'h405);
        chk("mid_beat5_vld", vld, 1);
        #2;
        rst_l = 1'b0;
        #1;
        chk("mid_rst_vld", vld, 0);
        chk("mid_rst_req", req, 0);
        chk("mid_rst_ecc", ecc, 0);
        chk("mid_rst_dat_rdy", bus.dat_rdy, 0);
        chk("mid_rst_idle", idle, 0);
        step();
        step();
        rst_l = 1'b1;
        @(negedge clk);
        chk("rel_idle", idle, 1);
        chk("rel_dat_rdy", bus.dat_rdy, 1);
        chk("rel_iq", dut.u_iq.cnt, 16);
        chk("rel_wib", dut.u_wib.cnt, 4);
        step();

        // Table-driven acceptance gating with a full buffer
        do_reset();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 24; c++) begin
                bus.dat_vld  = 1'b1;
                bus.dat_word = $urandom;
                bus.dat_ecc  = 7'($urandom);
                step();
            end
            bus.up_vld   = tbl[r].vld;
            bus.up_is_wr = tbl[r].wr;
            bus.up_hdr   = {$urandom, $urandom};
            por          = tbl[r].por;
            @(negedge clk);
            chk("tbl_up_rdy", bus.up_rdy, tbl[r].rdy);
            step();
            bus.up_vld = 1'b0;
            por = 1'b0;
        end
        clear_inputs();
        repeat (25) step();

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.up_vld   = ($urandom_range(0, 2) != 0);
            bus.up_is_wr = 1'($urandom_range(0, 1));
            bus.up_hdr   = {$urandom, $urandom};
            bus.dat_vld  = ($urandom_range(0, 9) < 7);
            bus.dat_word = $urandom;
            bus.dat_ecc  = 7'($urandom);
            por          = ($urandom_range(0, 9) == 0);
            iq_deq       = ($urandom_range(0, 5) == 0);
            wib_deq      = ($urandom_range(0, 11) == 0);
            rst_l        = ($urandom_range(0, 999) != 0);
            step();
        end
        rst_l = 1'b1;
        clear_inputs();
        repeat (25) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
